// File: rtl/mmio_controller_pkg.sv
// Shared constants for the memory-mapped I/O controller: address map, window and field widths.
package mmio_controller_pkg;

  localparam int unsigned DBITS       = 32;
  localparam int unsigned HEX_W       = 16;
  localparam int unsigned LEDR_W      = 10;
  localparam int unsigned KEY_W       = 4;
  localparam int unsigned SW_W        = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  localparam logic [3:0]       IO_WINDOW  = 4'hF;
  localparam logic [DBITS-1:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [DBITS-1:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [DBITS-1:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDR_KSTAT = 32'hF000_0110;

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchronizer plus per-bit saturating-mismatch counter; a bit's stable value
// only follows its synchronized input after DEBOUNCE_CYCLES consecutive mismatching cycles.
module io_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise_c
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] accept_c;

  // accept_c marks the edge on which a bit's stable value will flip
  always_comb begin
    accept_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      accept_c[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise_c = accept_c & sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept_c[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mmio_controller.sv
// I/O window decoder beside data memory: HEX/LEDR output registers, debounced KEY/SW
// inputs and a sticky write-1-to-clear key-press status register.
module mmio_controller
  import mmio_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  addr,
  input  logic              wr_en,
  input  logic [DBITS-1:0]  wr_data,
  output logic [DBITS-1:0]  rd_data,
  output logic              io_sel,
  input  logic [KEY_W-1:0]  key_n,
  input  logic [SW_W-1:0]   sw,
  output logic [HEX_W-1:0]  hex_out,
  output logic [LEDR_W-1:0] ledr_out,
  output logic              key_event
);

  logic [KEY_W-1:0] key_db;
  logic [KEY_W-1:0] key_rise_c;
  logic [SW_W-1:0]  sw_db;
  logic [SW_W-1:0]  sw_rise_unused;
  logic [KEY_W-1:0] kstat;
  logic [KEY_W-1:0] kstat_next_c;
  logic             hex_we_c;
  logic             ledr_we_c;
  logic             kstat_we_c;
  logic             unused_wr_bits;

  // Keys are inverted ahead of the synchronizer so that pressed reads as 1
  io_debouncer #(.WIDTH(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk    (clk),
    .rst_n  (reset),
    .raw    (~key_n),
    .stable (key_db),
    .rise_c (key_rise_c)
  );

  io_debouncer #(.WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk    (clk),
    .rst_n  (reset),
    .raw    (sw),
    .stable (sw_db),
    .rise_c (sw_rise_unused)
  );

  assign unused_wr_bits = ^wr_data[DBITS-1:HEX_W];

  assign io_sel     = (addr[DBITS-1:DBITS-4] == IO_WINDOW);
  assign hex_we_c   = wr_en && (addr == ADDR_HEX);
  assign ledr_we_c  = wr_en && (addr == ADDR_LEDR);
  assign kstat_we_c = wr_en && (addr == ADDR_KSTAT);

  // A new press in the same cycle as a clear keeps the bit set
  always_comb begin
    kstat_next_c = kstat;
    if (kstat_we_c) begin
      kstat_next_c = kstat_next_c & ~wr_data[KEY_W-1:0];
    end
    kstat_next_c = kstat_next_c | key_rise_c;
  end

  always_comb begin
    rd_data = '0;
    if (io_sel) begin
      case (addr)
        ADDR_HEX:   rd_data = DBITS'(hex_out);
        ADDR_LEDR:  rd_data = DBITS'(ledr_out);
        ADDR_KEY:   rd_data = DBITS'(key_db);
        ADDR_SW:    rd_data = DBITS'(sw_db);
        ADDR_KSTAT: rd_data = DBITS'(kstat);
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_out   <= '0;
      ledr_out  <= '0;
      kstat     <= '0;
      key_event <= 1'b0;
    end else begin
      if (hex_we_c)  hex_out  <= wr_data[HEX_W-1:0];
      if (ledr_we_c) ledr_out <= wr_data[LEDR_W-1:0];
      kstat     <= kstat_next_c;
      key_event <= |kstat_next_c;
    end
  end

endmodule
